vec_hazard_sequencer: RTL
=========================

Name: vec_hazard_sequencer

Overview:
Issue controller for the 4-stage vector pipeline (decode, execute, memory, write-back). The datapath has no forwarding paths, so this block tracks in-flight vector-register writes with a per-register scoreboard. It stalls fetch and decode and injects an execute bubble on read-after-write hazards. It also runs program start, drain-on-halt and done sequencing, and keeps a hazard-stall performance counter.

Parameters:
NREG, 16, number of vector registers tracked
AW, 4, register address width
WB_DIST, 3, cycles from decode issue until the written value is readable by an instruction in decode; valid range 2..7
CW, 16, width of the stall counter

Ports:
clk  input  1  pipeline clock
reset  input  1  asynchronous, active-high
Start  input  1  one-cycle pulse; starts execution from IDLE or DONE
InstrValidD  input  1  decode stage holds a real instruction
RegWriteD  input  1  decoded instruction writes a vector register
WA3D  input  AW  destination register (InstrD[24:21] field)
RA1D  input  AW  source register 1
RA2D  input  AW  source register 2, after the RegSrc mux
UsesRA2D  input  1  source register 2 is actually read
HaltD  input  1  decoded instruction is a halt
StallF  output  1  hold PC and the IF/ID register
StallD  output  1  hold the decode instruction
FlushE  output  1  load a bubble into the ID/EX register (all control bits 0)
Busy  output  1  state is RUN or DRAIN
Done  output  1  state is DONE
StallCount  output  CW  number of hazard-stall cycles since the last Start

Behaviour:
- Reset (async): state=IDLE; all scoreboard counters=0; StallCount=0; drain counter=0.
- Reset values of outputs: StallF=1, StallD=1, FlushE=1, Busy=0, Done=0, StallCount=0.
- Reset asserted mid-operation aborts immediately; the scoreboard is cleared with it.
- Scoreboard: one 3-bit down-counter per register. Each nonzero counter decrements by 1 every cycle in every state, stalls included, because the pipeline drains behind the bubble.
- Issue: issue=InstrValidD & ~hazard & state==RUN.
- On issue with RegWriteD=1, counter[WA3D] loads WB_DIST-1. The load overrides the decrement in the same cycle and reloads a counter that is already nonzero.
- Hazard (combinational): InstrValidD & ((counter[RA1D]!=0) | (UsesRA2D & counter[RA2D]!=0)).
- A source equal to the instruction's own WA3D is not a hazard; the read sees the old value.
- Timing: a writer issued at cycle t is readable by a dependent instruction in decode at t+WB_DIST. For WB_DIST=3 the dependent instruction stalls at t+1 and t+2 and issues at t+3.
- Outputs in RUN: StallF=StallD=FlushE=hazard.
- StallCount increments by 1 on each RUN cycle with hazard=1 and saturates at all-ones.
- FSM transitions:
  - IDLE: all stalls=1. Start -> RUN; StallCount is cleared on entry.
  - RUN: issue with HaltD=1 -> DRAIN; the halt instruction is itself issued, and drain counter loads WB_DIST.
  - DRAIN: StallF=StallD=FlushE=1; drain counter decrements each cycle. Exit to DONE when drain counter==0 and all scoreboard counters are 0.
  - DONE: all stalls=1; Done=1. Start -> RUN, with StallCount cleared.
- Start outside IDLE/DONE is ignored.
- A halt that is itself hazarded waits in decode like any other instruction and enters DRAIN only when it issues.
- InstrValidD=0 never stalls and never loads the scoreboard.

Test Plan:
- Reset mid-RUN with counter[3]=2 -> same cycle StallF=1, Busy=0; after reset release all counters are 0 and a reader of R3 issues with no stall after Start.
- Start, then write R5 at cycle t, then a reader of R5 via RA1 at t+1 -> StallF/StallD/FlushE=1 at t+1 and t+2, issue at t+3, StallCount=2.
- Write R2 at t, an unrelated instruction at t+1, reader of R2 via RA2 (UsesRA2D=1) at t+2 -> exactly 1 stall cycle. Same case with UsesRA2D=0 -> 0 stalls.
- Write R7 at t, write R7 again at t+1 (reload), reader at t+2 -> stalls at t+2 and t+3, issue at t+4.
- Halt issued at t with R1 pending -> DRAIN from t+1 with all stalls=1; Done=1 at t+1+WB_DIST. A following Start returns to RUN with StallCount=0.
- Reader with RA1D==WA3D and no pending write -> no stall; counter[WA3D]=2 on the next cycle.

Source files
------------

// File: rtl/vec_hazard_sequencer.sv
// Issue controller for a 4-stage vector pipeline that has no forwarding.
// It tracks pending register writes, stalls on read-after-write hazards and sequences start/drain/done.
module vec_hazard_sequencer #(
  parameter int NREG    = 16,
  parameter int AW      = 4,
  parameter int WB_DIST = 3,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          Start,
  input  logic          InstrValidD,
  input  logic          RegWriteD,
  input  logic [AW-1:0] WA3D,
  input  logic [AW-1:0] RA1D,
  input  logic [AW-1:0] RA2D,
  input  logic          UsesRA2D,
  input  logic          HaltD,
  output logic          StallF,
  output logic          StallD,
  output logic          FlushE,
  output logic          Busy,
  output logic          Done,
  output logic [CW-1:0] StallCount
);

  // state | meaning
  // IDLE  | waiting for Start after reset, pipeline held
  // RUN   | issuing; stalls only on a RAW hazard
  // DRAIN | halt issued, waiting for in-flight writes to retire
  // DONE  | program finished, waiting for Start
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [2:0] SB_LOAD    = 3'(WB_DIST - 1);
  localparam logic [2:0] DRAIN_LOAD = 3'(WB_DIST);

  state_t          state_q, state_d;
  logic [2:0]      sb_q [NREG];
  logic [2:0]      sb_d [NREG];
  logic [2:0]      drain_q, drain_d;
  logic [CW-1:0]   stall_cnt_q, stall_cnt_d;
  logic            hazard, issue, sb_idle;

  // A source matching the instruction's own destination is not checked against
  // the new write: it reads the old value, so only already-pending writes matter.
  always_comb begin
    hazard = InstrValidD & ((sb_q[RA1D] != 3'd0) | (UsesRA2D & (sb_q[RA2D] != 3'd0)));
    issue  = InstrValidD & ~hazard & (state_q == S_RUN);
  end

  always_comb begin
    sb_idle = 1'b1;
    for (int i = 0; i < NREG; i++) begin
      if (sb_q[i] != 3'd0) sb_idle = 1'b0;
      sb_d[i] = (sb_q[i] != 3'd0) ? sb_q[i] - 3'd1 : 3'd0;
      if (issue && RegWriteD && (WA3D == AW'(i))) sb_d[i] = SB_LOAD;
    end
  end

  always_comb begin
    state_d     = state_q;
    drain_d     = (drain_q != 3'd0) ? drain_q - 3'd1 : 3'd0;
    stall_cnt_d = stall_cnt_q;
    StallF      = 1'b1;
    StallD      = 1'b1;
    FlushE      = 1'b1;
    Busy        = 1'b0;
    Done        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d     = S_RUN;
          stall_cnt_d = '0;
        end
      end
      S_RUN: begin
        Busy   = 1'b1;
        StallF = hazard;
        StallD = hazard;
        FlushE = hazard;
        if (hazard && (stall_cnt_q != {CW{1'b1}})) stall_cnt_d = stall_cnt_q + 1'b1;
        if (issue && HaltD) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_LOAD;
        end
      end
      S_DRAIN: begin
        Busy = 1'b1;
        // Exit on the edge where the drain count reaches zero so DONE lands WB_DIST cycles into DRAIN.
        if ((drain_d == 3'd0) && sb_idle) state_d = S_DONE;
      end
      S_DONE: begin
        Done = 1'b1;
        if (Start) begin
          state_d     = S_RUN;
          stall_cnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      drain_q     <= 3'd0;
      stall_cnt_q <= '0;
      for (int i = 0; i < NREG; i++) sb_q[i] <= 3'd0;
    end else begin
      state_q     <= state_d;
      drain_q     <= drain_d;
      stall_cnt_q <= stall_cnt_d;
      for (int i = 0; i < NREG; i++) sb_q[i] <= sb_d[i];
    end
  end

  assign StallCount = stall_cnt_q;

endmodule
